// File: rtl/cursor_controller_pkg.sv
// cursor_controller_pkg
//   Shared definitions for the terminal cursor controller: command opcodes,
//   controller FSM states and a helper that tells which opcodes move the cursor.
//   No ports; imported by the interface, the top and the blink timer.
package cursor_controller_pkg;

  localparam int OP_W = 4;

  // ADVANCE needs its own code, which is why opcodes are 4 bits wide
  typedef enum logic [OP_W-1:0] {
    OP_NOP     = 4'd0,
    OP_LEFT    = 4'd1,
    OP_RIGHT   = 4'd2,
    OP_UP      = 4'd3,
    OP_DOWN    = 4'd4,
    OP_CR      = 4'd5,
    OP_HOME    = 4'd6,
    OP_SET     = 4'd7,
    OP_ADVANCE = 4'd8
  } cursor_op_e;

  typedef enum logic {
    ST_IDLE        = 1'b0,
    ST_SCROLL_WAIT = 1'b1
  } cursor_state_e;

  // Every defined opcode except NOP counts as a move and restarts the blink;
  // undefined codes behave like NOP
  function automatic logic is_move_op(cursor_op_e op);
    case (op)
      OP_LEFT, OP_RIGHT, OP_UP, OP_DOWN,
      OP_CR, OP_HOME, OP_SET, OP_ADVANCE: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cursor_controller_if.sv
// cursor_controller_if
//   Command channel from the command decoder to the cursor controller.
//   cmd_valid  decoder -> controller  command present
//   cmd_ready  controller -> decoder  command taken when valid & ready
//   cmd_op     decoder -> controller  opcode (cursor_op_e encoding)
//   cmd_col    decoder -> controller  SET target column
//   cmd_row    decoder -> controller  SET target row
interface cursor_controller_if
  import cursor_controller_pkg::*;
#(
  parameter int COL_W = 7,
  parameter int ROW_W = 5
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [OP_W-1:0]  cmd_op;
  logic [COL_W-1:0] cmd_col;
  logic [ROW_W-1:0] cmd_row;

  modport master (
    output cmd_valid, cmd_op, cmd_col, cmd_row,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_col, cmd_row,
    output cmd_ready
  );

endinterface

// File: rtl/cursor_controller_frame_blink_timer.sv
// cursor_controller_frame_blink_timer
//   Generates the cursor blink phase from frame timing. Counts rising edges of
//   vblank and toggles the phase every BLINK_FRAMES frames. A restart pulse
//   makes the cursor visible and starts a fresh on-phase.
//   px_clk   in   pixel clock
//   clr_n    in   asynchronous reset, active-low
//   vblank   in   frame blanking (px_clk domain)
//   restart  in   force blink=1 and clear the frame count
//   blink    out  1 = cursor drawn inverted this frame
module cursor_controller_frame_blink_timer #(
  parameter int BLINK_FRAMES = 16
) (
  input  logic px_clk,
  input  logic clr_n,
  input  logic vblank,
  input  logic restart,
  output logic blink
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             vblank_q;
  logic [CNT_W-1:0] frame_cnt;
  logic             frame_edge;

  assign frame_edge = vblank & ~vblank_q;

  // restart takes priority so a moving cursor never blinks off on the same edge
  always_ff @(posedge px_clk or negedge clr_n) begin
    if (!clr_n) begin
      vblank_q  <= 1'b0;
      frame_cnt <= '0;
      blink     <= 1'b1;
    end else begin
      vblank_q <= vblank;
      if (restart) begin
        frame_cnt <= '0;
        blink     <= 1'b1;
      end else if (frame_edge) begin
        if (frame_cnt == CNT_LAST) begin
          frame_cnt <= '0;
          blink     <= ~blink;
        end else begin
          frame_cnt <= frame_cnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/cursor_controller.sv
// cursor_controller
//   Owns the terminal cursor position. Takes movement commands over a
//   valid/ready channel, clamps (col,row) to the screen, requests a one-line
//   scroll on a line feed at the bottom row and drives the blink phase.
//   px_clk        in   pixel clock
//   clr_n         in   asynchronous reset, active-low
//   cmd           slave command channel (cursor_controller_if)
//   vblank        in   frame blanking from the sync generator
//   scroll_req    out  request a one-line scroll up
//   scroll_ack    in   scroll complete
//   cursor_x      out  current column
//   cursor_y      out  current row
//   cursor_blink  out  1 = cursor drawn inverted this frame
module cursor_controller
  import cursor_controller_pkg::*;
#(
  parameter int COLS         = 80,
  parameter int ROWS         = 24,
  parameter int COL_W        = 7,
  parameter int ROW_W        = 5,
  parameter int AUTOWRAP     = 0,
  parameter int BLINK_FRAMES = 16
) (
  input  logic              px_clk,
  input  logic              clr_n,
  cursor_controller_if.slave cmd,
  input  logic              vblank,
  output logic              scroll_req,
  input  logic              scroll_ack,
  output logic [COL_W-1:0]  cursor_x,
  output logic [ROW_W-1:0]  cursor_y,
  output logic              cursor_blink
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);

  cursor_state_e    state, state_nxt;
  cursor_op_e       op;
  logic [COL_W-1:0] col_nxt;
  logic [ROW_W-1:0] row_nxt;
  logic             accept;
  logic             restart;

  assign op            = cursor_op_e'(cmd.cmd_op);
  assign cmd.cmd_ready = (state == ST_IDLE);
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;
  // state is a flop, so scroll_req is a registered output
  assign scroll_req    = (state == ST_SCROLL_WAIT);

  always_ff @(posedge px_clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= ST_IDLE;
      cursor_x <= '0;
      cursor_y <= '0;
    end else begin
      state    <= state_nxt;
      cursor_x <= col_nxt;
      cursor_y <= row_nxt;
    end
  end

  // Bounds are checked before every increment/decrement, so the arithmetic
  // never wraps. A line feed at the bottom row leaves the row alone and
  // hands the scroll to the video side instead.
  always_comb begin
    state_nxt = state;
    col_nxt   = cursor_x;
    row_nxt   = cursor_y;
    restart   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          restart = is_move_op(op);
          case (op)
            OP_LEFT:  if (cursor_x != '0) col_nxt = cursor_x - COL_ONE;
            OP_RIGHT: if (cursor_x < COL_MAX) col_nxt = cursor_x + COL_ONE;
            OP_UP:    if (cursor_y != '0) row_nxt = cursor_y - ROW_ONE;
            OP_DOWN: begin
              if (cursor_y < ROW_MAX) row_nxt = cursor_y + ROW_ONE;
              else                    state_nxt = ST_SCROLL_WAIT;
            end
            OP_CR:    col_nxt = '0;
            OP_HOME: begin
              col_nxt = '0;
              row_nxt = '0;
            end
            OP_SET: begin
              col_nxt = (cmd.cmd_col > COL_MAX) ? COL_MAX : cmd.cmd_col;
              row_nxt = (cmd.cmd_row > ROW_MAX) ? ROW_MAX : cmd.cmd_row;
            end
            OP_ADVANCE: begin
              if (cursor_x < COL_MAX) begin
                col_nxt = cursor_x + COL_ONE;
              end else if (AUTOWRAP != 0) begin
                col_nxt = '0;
                if (cursor_y < ROW_MAX) row_nxt = cursor_y + ROW_ONE;
                else                    state_nxt = ST_SCROLL_WAIT;
              end
            end
            default: ;
          endcase
        end
      end
      ST_SCROLL_WAIT: begin
        if (scroll_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  cursor_controller_frame_blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .px_clk  (px_clk),
    .clr_n   (clr_n),
    .vblank  (vblank),
    .restart (restart),
    .blink   (cursor_blink)
  );

endmodule

// File: tb/tb_cursor_controller.sv
// tb_cursor_controller
//   Bench for cursor_controller with AUTOWRAP=1 and BLINK_FRAMES=2. A driver
//   applies directed then random commands one cycle at a time and predicts the
//   outcome with a screen-level model; a monitor pops expectations whenever
//   the DUT takes a command, sees a vblank rising edge or sees scroll_ack.
module tb_cursor_controller;
  import cursor_controller_pkg::*;

  localparam int COLS         = 80;
  localparam int ROWS         = 24;
  localparam int COL_W        = 7;
  localparam int ROW_W        = 5;
  localparam int AUTOWRAP     = 1;
  localparam int BLINK_FRAMES = 2;

  logic             px_clk = 1'b0;
  logic             clr_n = 1'b0;
  logic             vblank = 1'b0;
  logic             scroll_ack = 1'b0;
  logic             scroll_req;
  logic             cursor_blink;
  logic [COL_W-1:0] cursor_x;
  logic [ROW_W-1:0] cursor_y;

  cursor_controller_if #(.COL_W(COL_W), .ROW_W(ROW_W)) cmd_if ();

  cursor_controller #(
    .COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W),
    .AUTOWRAP(AUTOWRAP), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .px_clk       (px_clk),
    .clr_n        (clr_n),
    .cmd          (cmd_if),
    .vblank       (vblank),
    .scroll_req   (scroll_req),
    .scroll_ack   (scroll_ack),
    .cursor_x     (cursor_x),
    .cursor_y     (cursor_y),
    .cursor_blink (cursor_blink)
  );

  always #5 px_clk = ~px_clk;

  typedef struct {
    int x;
    int y;
    bit blink;
    bit scroll;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;

  // screen-level reference: position, whether a scroll is pending, and how
  // many frames have gone by since the cursor last moved
  int m_col, m_row, m_frames;
  bit m_scroll, m_prev_v;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  function automatic void model_reset();
    m_col = 0; m_row = 0; m_frames = 0; m_scroll = 1'b0; m_prev_v = 1'b0;
  endfunction

  function automatic void model_line_feed();
    if (m_row == ROWS - 1) m_scroll = 1'b1;
    else                   m_row = m_row + 1;
  endfunction

  function automatic bit model_step(input bit valid, input int op, input int ccol,
                                    input int crow, input bit v, input bit ack,
                                    output exp_t e);
    bit acc, vedge;
    acc      = valid && !m_scroll;
    vedge    = v && !m_prev_v;
    m_prev_v = v;
    if (!acc && m_scroll && ack) m_scroll = 1'b0;
    if (acc) begin
      case (op)
        1: m_col = (m_col > 0) ? m_col - 1 : 0;
        2: m_col = (m_col < COLS - 1) ? m_col + 1 : COLS - 1;
        3: m_row = (m_row > 0) ? m_row - 1 : 0;
        4: model_line_feed();
        5: m_col = 0;
        6: begin m_col = 0; m_row = 0; end
        7: begin
          m_col = (ccol < COLS) ? ccol : COLS - 1;
          m_row = (crow < ROWS) ? crow : ROWS - 1;
        end
        8: begin
          if (m_col < COLS - 1) m_col = m_col + 1;
          else if (AUTOWRAP != 0) begin m_col = 0; model_line_feed(); end
        end
        default: ;
      endcase
    end
    if (acc && op != 0) m_frames = 0;
    else if (vedge)     m_frames = m_frames + 1;
    e.x      = m_col;
    e.y      = m_row;
    e.blink  = ((m_frames / BLINK_FRAMES) % 2) == 0;
    e.scroll = m_scroll;
    return acc || vedge || ack;
  endfunction

  // one clock cycle of stimulus, driven on the falling edge
  task automatic applyStimulus(input bit valid, input int op, input int ccol,
                               input int crow, input bit v, input bit ack);
    exp_t e;
    @(negedge px_clk);
    cmd_if.cmd_valid = valid;
    cmd_if.cmd_op    = 4'(op);
    cmd_if.cmd_col   = COL_W'(ccol);
    cmd_if.cmd_row   = ROW_W'(crow);
    vblank           = v;
    scroll_ack       = ack;
    if (model_step(valid, op, ccol, crow, v, ack, e)) sb_q.push_back(e);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  // monitor: a command handshake, a vblank rising edge or scroll_ack each
  // produce exactly one expectation, checked just after the edge
  bit mon_prev_v = 1'b0;
  always @(posedge px_clk) begin : monitor
    bit hs, ve, ak;
    exp_t e;
    if (!clr_n) begin
      mon_prev_v = 1'b0;
    end else begin
      hs = cmd_if.cmd_valid && cmd_if.cmd_ready;
      ve = vblank && !mon_prev_v;
      ak = scroll_ack;
      mon_prev_v = vblank;
      if (hs || ve || ak) begin
        #1;
        checkOutput("sb_nonempty", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          checkOutput("cursor_x", int'(cursor_x), e.x);
          checkOutput("cursor_y", int'(cursor_y), e.y);
          checkOutput("cursor_blink", int'(cursor_blink), int'(e.blink));
          checkOutput("scroll_req", int'(scroll_req), int'(e.scroll));
          checkOutput("cmd_ready", int'(cmd_if.cmd_ready), int'(!e.scroll));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = '0;
    cmd_if.cmd_col   = '0;
    cmd_if.cmd_row   = '0;
    model_reset();

    // reset values while clr_n is held low
    repeat (3) @(negedge px_clk);
    checkOutput("reset_x", int'(cursor_x), 0);
    checkOutput("reset_y", int'(cursor_y), 0);
    checkOutput("reset_scroll_req", int'(scroll_req), 0);
    checkOutput("reset_blink", int'(cursor_blink), 1);
    clr_n = 1'b1;
    #1 checkOutput("ready_after_reset", int'(cmd_if.cmd_ready), 1);

    // walk to (5,2)
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, OP_RIGHT, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, OP_DOWN, 0, 0, 1'b0, 1'b0);
    idleCycles(1);

    // clamping at both corners and on SET
    applyStimulus(1'b1, OP_HOME, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_LEFT, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_UP, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_SET, 100, 30, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_RIGHT, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_CR, 0, 0, 1'b0, 1'b0);

    // line feed at the bottom row: scroll, commands held off, then ack
    applyStimulus(1'b1, OP_DOWN, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, OP_RIGHT, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1);
    idleCycles(2);
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1);
    idleCycles(1);

    // autowrap mid-screen and at the bottom row
    applyStimulus(1'b1, OP_SET, 79, 5, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_ADVANCE, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_SET, 79, 23, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_ADVANCE, 0, 0, 1'b0, 1'b0);
    idleCycles(3);
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1);
    idleCycles(1);

    // blink: ten frames with no commands, then a move during the off phase
    for (int f = 0; f < 10; f++) begin
      applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
      idleCycles(3);
    end
    applyStimulus(1'b1, OP_RIGHT, 0, 0, 1'b0, 1'b0);
    // move on the same edge as a vblank rise
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 1'b0);
    applyStimulus(1'b1, OP_LEFT, 0, 0, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(1'b1, OP_NOP, 0, 0, 1'b1, 1'b0);
    idleCycles(2);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bit v, a, valid;
      int op;
      valid = ($urandom_range(0, 9) < 6);
      op    = $urandom_range(0, 8);
      v     = ($urandom_range(0, 3) == 0);
      a     = m_scroll ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 15) == 0);
      applyStimulus(valid, op, $urandom_range(0, 127), $urandom_range(0, 31), v, a);
    end
    idleCycles(2);
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1);
    idleCycles(2);

    // reset in the middle of a scroll wait
    applyStimulus(1'b1, OP_SET, 10, 23, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_DOWN, 0, 0, 1'b0, 1'b0);
    idleCycles(2);
    @(negedge px_clk);
    #2 clr_n = 1'b0;
    #1;
    checkOutput("midscroll_reset_scroll_req", int'(scroll_req), 0);
    checkOutput("midscroll_reset_x", int'(cursor_x), 0);
    checkOutput("midscroll_reset_y", int'(cursor_y), 0);
    checkOutput("midscroll_reset_blink", int'(cursor_blink), 1);
    checkOutput("midscroll_reset_ready", int'(cmd_if.cmd_ready), 1);
    cmd_if.cmd_valid = 1'b0;
    vblank           = 1'b0;
    scroll_ack       = 1'b0;
    model_reset();
    repeat (2) @(negedge px_clk);
    clr_n = 1'b1;

    for (int i = 0; i < 100; i++) begin
      applyStimulus(($urandom_range(0, 1) == 1), $urandom_range(0, 8),
                    $urandom_range(0, 127), $urandom_range(0, 31),
                    ($urandom_range(0, 3) == 0), m_scroll);
    end
    idleCycles(3);
    checkOutput("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
